// File: rtl/la_step_pkg.sv
// la_step_pkg: shared types, LA/GPIO bit offsets and the ALU for the LA step checker
package la_step_pkg;
    localparam int P_STEP_W = 6;
    localparam int P_DATA_W = 32;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_MUL, OP_ILL} op_e;
    typedef enum logic [1:0] {ST_PASS = 2'b00, ST_MISM = 2'b01, ST_ILL = 2'b10, ST_OVR = 2'b11} status_e;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_CHECK, S_REPORT} state_e;
    localparam int LA_A     = 0;
    localparam int LA_B     = 32;
    localparam int LA_EXP   = 64;
    localparam int LA_OP    = 96;
    localparam int LA_START = 99;
    localparam int LA_CLEAR = 100;
    localparam int LO_RES   = 0;
    localparam int LO_BUSY  = 32;
    localparam int LO_STEP  = 33;
    localparam int LO_STAT  = 39;
    localparam int LO_DONE  = 41;
    localparam int IO_STEP  = 20;
    localparam int IO_BUSY  = 26;
    localparam int IO_STAT  = 36;
    localparam logic [37:0] IO_OEB = 38'h0FF80FFFFF;
    function automatic logic [P_DATA_W-1:0] alu(op_e op, logic [P_DATA_W-1:0] a, logic [P_DATA_W-1:0] b);
        return op == OP_ADD ? a + b :
               op == OP_SUB ? a - b :
               op == OP_AND ? a & b :
               op == OP_OR  ? a | b :
               op == OP_XOR ? a ^ b :
               op == OP_SHL ? a << b[4:0] : '0;
    endfunction
endpackage

// File: rtl/la_step_mul.sv
// la_step_mul: iterative shift-add multiplier, one multiplier bit per cycle LSB first, low W bits kept
module la_step_mul import la_step_pkg::*; #(
    parameter int W = P_DATA_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_done,
    output logic [W-1:0] o_product
);
    localparam int CW = $clog2(W);
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    // o_done flags the cycle whose edge performs the final iteration
    assign o_done    = r_busy && r_cnt == CW'(W - 1);
    assign o_product = r_acc;
    // load operands on start, then accumulate the shifted multiplicand for each set multiplier bit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || i_clr) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc  <= r_acc + (r_b[0] ? r_a : '0);
            r_a    <= r_a << 1;
            r_b    <= r_b >> 1;
            r_cnt  <= r_cnt + 1'b1;
            r_busy <= !o_done;
        end
    end
endmodule

// File: rtl/la_step_checker.sv
// la_step_checker: runs LA-posted commands, checks the result and publishes step/status on GPIO and LA
module la_step_checker import la_step_pkg::*; #(
    parameter int STEP_W = P_STEP_W,
    parameter int DATA_W = P_DATA_W
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oenb,
    output logic [127:0] la_data_out,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb
);
    logic              r_armed;
    logic              r_start_q;
    logic              r_ovr;
    logic              r_mis;
    logic              r_done;
    state_e            r_state;
    op_e               r_op;
    status_e           r_status;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_exp;
    logic [DATA_W-1:0] r_calc;
    logic [DATA_W-1:0] r_result;
    logic [STEP_W-1:0] r_step;
    logic              w_clr;
    logic              w_start;
    logic              w_busy;
    logic              w_ovr;
    logic              w_mul_start;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_prod;
    logic [DATA_W-1:0] w_res;
    op_e               w_op;
    logic              w_unused;
    assign w_clr       = la_data_in[LA_CLEAR] & ~la_oenb[LA_CLEAR];
    assign w_start     = r_armed & ~la_oenb[LA_START] & (la_data_in[LA_START] ^ r_start_q);
    assign w_op        = op_e'(la_data_in[LA_OP +: 3]);
    assign w_busy      = r_state != S_IDLE;
    assign w_ovr       = r_ovr | w_start;
    assign w_mul_start = w_start & ~w_busy & ~w_clr & (w_op == OP_MUL);
    assign w_res       = r_op == OP_MUL ? w_prod : r_calc;
    assign w_unused    = &{1'b0, la_data_in[127:101], la_oenb[127:101], la_oenb[98:0]};
    assign io_oeb      = IO_OEB;
    la_step_mul #(.W(DATA_W)) u_mul (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_clr     (w_clr),
        .i_start   (w_mul_start),
        .i_a       (la_data_in[LA_A +: DATA_W]),
        .i_b       (la_data_in[LA_B +: DATA_W]),
        .o_done    (w_mul_done),
        .o_product (w_prod)
    );
    // start edge detector: the first cycle out of reset only arms it so a level held through reset never fires
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_armed   <= 1'b0;
            r_start_q <= 1'b0;
        end else if (!r_armed) begin
            r_armed   <= 1'b1;
            r_start_q <= la_data_in[LA_START];
        end else if (!la_oenb[LA_START]) begin
            r_start_q <= la_data_in[LA_START];
        end
    end
    // command FSM: clear aborts everything, starts while busy only mark the running command as overrun
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state  <= S_IDLE;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_exp    <= '0;
            r_calc   <= '0;
            r_mis    <= 1'b0;
            r_ovr    <= 1'b0;
            r_step   <= '0;
            r_status <= ST_PASS;
            r_result <= '0;
            r_done   <= 1'b0;
        end else if (w_clr) begin
            r_state  <= S_IDLE;
            r_ovr    <= 1'b0;
            r_step   <= '0;
            r_status <= ST_PASS;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_op    <= w_op;
                    r_a     <= la_data_in[LA_A +: DATA_W];
                    r_b     <= la_data_in[LA_B +: DATA_W];
                    r_exp   <= la_data_in[LA_EXP +: DATA_W];
                    r_ovr   <= 1'b0;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_calc  <= alu(r_op, r_a, r_b);
                    r_state <= (r_op != OP_MUL || w_mul_done) ? S_CHECK : S_CALC;
                end
                S_CHECK: begin
                    r_calc  <= w_res;
                    r_mis   <= w_res != r_exp;
                    r_state <= S_REPORT;
                end
                S_REPORT: begin
                    r_step   <= r_step + 1'b1;
                    r_status <= r_op == OP_ILL ? ST_ILL : w_ovr ? ST_OVR : r_mis ? ST_MISM : ST_PASS;
                    r_result <= r_calc;
                    r_done   <= ~r_done;
                    r_state  <= S_IDLE;
                end
            endcase
            if (w_busy && w_start) r_ovr <= 1'b1;
        end
    end
    // publish registered state onto the LA readback and the GPIO pins
    always_comb begin
        la_data_out                    = '0;
        la_data_out[LO_RES +: DATA_W]  = r_result;
        la_data_out[LO_BUSY]           = w_busy;
        la_data_out[LO_STEP +: STEP_W] = r_step;
        la_data_out[LO_STAT +: 2]      = r_status;
        la_data_out[LO_DONE]           = r_done;
        io_out                         = '0;
        io_out[IO_STEP +: STEP_W]      = r_step;
        io_out[IO_BUSY]                = w_busy;
        io_out[IO_STAT +: 2]           = r_status;
    end
endmodule
